// File: rtl/lane_deskew_collector.sv
// Rx lane collector/deskewer: aligns the active lanes on sync markers, pops them in lockstep and
// presents one wide word, with lane mask, align timeout, dissync counter and soft-reset pulse.
module lane_deskew_collector #(
  parameter int LANES    = 4,
  parameter int UNITW    = 64,
  parameter int TMO_W    = 4,
  parameter int SRST_LEN = 16,
  parameter int DSC_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_enable,
  input  logic [LANES-1:0]       lane_mask,
  input  logic [TMO_W-1:0]       timeout_limit,
  input  logic                   clear_cnt,
  input  logic [LANES-1:0]       in_block_lock,
  input  logic [LANES-1:0]       in_canpop,
  input  logic [LANES-1:0]       in_issync,
  input  logic [LANES-1:0]       in_dissync,
  input  logic [LANES*UNITW-1:0] in_rxdata,
  input  logic [LANES*LANES-1:0] in_bl_remote,
  input  logic [LANES-1:0]       in_bl_remote_en,
  output logic [LANES-1:0]       out_pop,
  output logic [LANES*UNITW-1:0] out_rxdata,
  output logic                   out_rxdata_valid,
  output logic [LANES-1:0]       out_blocklock,
  output logic                   out_allsync,
  output logic                   lanes_locked,
  output logic                   timeout_flag,
  output logic [DSC_W-1:0]       dissync_counter,
  output logic                   softreset,
  output logic [LANES-1:0]       out_bl_remote,
  output logic                   out_bl_remote_en
);

  localparam int SRST_W = (SRST_LEN > 1) ? $clog2(SRST_LEN) : 1;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_ALIGN  = 2'd1
  } state_t;

  state_t             state, state_nxt;
  logic [LANES-1:0]   bl_s1, bl_s2;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic               tmo_hit;
  logic               lock_nxt;
  logic               valid_in;
  logic [LANES-1:0]   pop;
  logic               srst_req;
  logic [SRST_W-1:0]  srst_cnt;
  logic [LANES-1:0]   rem_sel;

  logic [LANES-1:0] act;
  logic             exist_sync, all_sync, all_canpop, exist_dissync;

  assign act           = bl_s2 & lane_mask;
  assign exist_sync    = |(act & in_issync);
  assign all_sync      = &(~act | in_issync);
  assign all_canpop    = &(~act | in_canpop);
  assign exist_dissync = |(in_dissync & lane_mask);

  assign out_blocklock    = bl_s2;
  assign out_allsync      = all_sync & (act != '0);
  assign out_rxdata       = in_rxdata;
  assign out_pop          = pop;
  assign out_rxdata_valid = valid_in & lanes_locked & in_enable;

  // NOTE: every variable gets a default before any branch so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo_cnt;
    tmo_hit   = 1'b0;
    lock_nxt  = lanes_locked;
    valid_in  = 1'b0;
    pop       = '0;
    if (act == '0) begin
      lock_nxt = 1'b0;
    end else begin
      case (state)
        ST_NORMAL: begin
          if (!exist_sync) begin
            if (all_canpop) begin
              pop      = act;
              valid_in = 1'b1;
            end
          end else if (all_sync) begin
            if (all_canpop) begin
              pop      = act;
              lock_nxt = 1'b1;
            end
          end else begin
            state_nxt = ST_ALIGN;
            pop       = act & in_canpop & ~in_issync;
          end
        end
        ST_ALIGN: begin
          if (all_sync && all_canpop) begin
            state_nxt = ST_NORMAL;
            pop       = act;
            lock_nxt  = 1'b1;
            tmo_nxt   = '0;
          end else begin
            // Lanes already showing their marker wait; the others drain up to theirs.
            pop = act & in_canpop & ~in_issync;
            if (timeout_limit != '0 && tmo_cnt == TMO_W'(timeout_limit - 1'b1)) begin
              lock_nxt = 1'b0;
              tmo_hit  = 1'b1;
              tmo_nxt  = '0;
            end else begin
              tmo_nxt = tmo_cnt + TMO_W'(1);
            end
          end
        end
        default: state_nxt = ST_NORMAL;
      endcase
    end
    if (!in_enable) pop = '0;
  end

  // Lowest-index lane with a valid remote slice wins; the last lane is the fallback.
  always_comb begin
    rem_sel = in_bl_remote[(LANES-1)*LANES +: LANES];
    for (int i = LANES - 1; i >= 0; i--) begin
      if (in_bl_remote_en[i]) rem_sel = in_bl_remote[i*LANES +: LANES];
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_NORMAL;
      bl_s1            <= '0;
      bl_s2            <= '0;
      tmo_cnt          <= '0;
      lanes_locked     <= 1'b0;
      timeout_flag     <= 1'b0;
      dissync_counter  <= '0;
      srst_req         <= 1'b0;
      srst_cnt         <= '0;
      softreset        <= 1'b0;
      out_bl_remote    <= '0;
      out_bl_remote_en <= 1'b0;
    end else if (in_enable) begin
      bl_s1   <= in_block_lock;
      bl_s2   <= bl_s1;
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;

      lanes_locked <= exist_dissync ? 1'b0 : lock_nxt;

      if (tmo_hit)        timeout_flag <= 1'b1;
      else if (clear_cnt) timeout_flag <= 1'b0;

      if (clear_cnt)
        dissync_counter <= '0;
      else if ((exist_dissync || !lock_nxt) && dissync_counter != '1)
        dissync_counter <= dissync_counter + DSC_W'(1);

      // One cycle of request latency, then a fixed-length pulse; dissync during it is ignored.
      if (srst_req) begin
        srst_req  <= 1'b0;
        softreset <= 1'b1;
        srst_cnt  <= SRST_W'(SRST_LEN - 1);
      end else if (softreset) begin
        if (srst_cnt == '0) softreset <= 1'b0;
        else                srst_cnt  <= srst_cnt - SRST_W'(1);
      end else if (exist_dissync) begin
        srst_req <= 1'b1;
      end

      out_bl_remote    <= rem_sel;
      out_bl_remote_en <= |in_bl_remote_en;
    end
  end

endmodule

// File: tb/tb_lane_deskew_collector.sv
// Directed self-checking bench for lane_deskew_collector (4 lanes, 8-bit units, 4-bit dissync counter).
module tb_lane_deskew_collector;

  localparam int LANES    = 4;
  localparam int UNITW    = 8;
  localparam int TMO_W    = 4;
  localparam int SRST_LEN = 16;
  localparam int DSC_W    = 4;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   in_enable;
  logic [LANES-1:0]       lane_mask;
  logic [TMO_W-1:0]       timeout_limit;
  logic                   clear_cnt;
  logic [LANES-1:0]       in_block_lock, in_canpop, in_issync, in_dissync;
  logic [LANES*UNITW-1:0] in_rxdata;
  logic [LANES*LANES-1:0] in_bl_remote;
  logic [LANES-1:0]       in_bl_remote_en;
  logic [LANES-1:0]       out_pop;
  logic [LANES*UNITW-1:0] out_rxdata;
  logic                   out_rxdata_valid;
  logic [LANES-1:0]       out_blocklock;
  logic                   out_allsync;
  logic                   lanes_locked;
  logic                   timeout_flag;
  logic [DSC_W-1:0]       dissync_counter;
  logic                   softreset;
  logic [LANES-1:0]       out_bl_remote;
  logic                   out_bl_remote_en;

  int tests  = 0;
  int failed = 0;

  lane_deskew_collector #(
    .LANES(LANES), .UNITW(UNITW), .TMO_W(TMO_W), .SRST_LEN(SRST_LEN), .DSC_W(DSC_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_enable(in_enable), .lane_mask(lane_mask),
    .timeout_limit(timeout_limit), .clear_cnt(clear_cnt), .in_block_lock(in_block_lock),
    .in_canpop(in_canpop), .in_issync(in_issync), .in_dissync(in_dissync),
    .in_rxdata(in_rxdata), .in_bl_remote(in_bl_remote), .in_bl_remote_en(in_bl_remote_en),
    .out_pop(out_pop), .out_rxdata(out_rxdata), .out_rxdata_valid(out_rxdata_valid),
    .out_blocklock(out_blocklock), .out_allsync(out_allsync), .lanes_locked(lanes_locked),
    .timeout_flag(timeout_flag), .dissync_counter(dissync_counter), .softreset(softreset),
    .out_bl_remote(out_bl_remote), .out_bl_remote_en(out_bl_remote_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_enable = 1'b1; lane_mask = 4'hF; timeout_limit = '0; clear_cnt = 1'b0;
    in_block_lock = 4'hF; in_canpop = 4'hF; in_issync = 4'h0; in_dissync = 4'h0;
    in_rxdata = 32'hA1B2C3D4; in_bl_remote = '0; in_bl_remote_en = '0;
    #12;
    check("rst_pop", out_pop, 0);
    check("rst_valid", out_rxdata_valid, 0);
    check("rst_locked", lanes_locked, 0);
    check("rst_flag", timeout_flag, 0);
    check("rst_cnt", dissync_counter, 0);
    check("rst_srst", softreset, 0);
    check("rst_bl", out_blocklock, 0);
    check("rst_rem_en", out_bl_remote_en, 0);
    reset_n = 1'b1;

    // T1: lock resync, free-running pops, valid only once locked
    tick(); tick();
    check("t1_bl", out_blocklock, 4'hF);
    check("t1_pop", out_pop, 4'hF);
    check("t1_valid_unlocked", out_rxdata_valid, 0);
    check("t1_data", out_rxdata, 32'hA1B2C3D4);
    in_issync = 4'hF; #1;
    check("t1_pop_sync", out_pop, 4'hF);
    tick(); in_issync = 4'h0; #1;
    check("t1_locked", lanes_locked, 1);
    check("t1_valid", out_rxdata_valid, 1);
    clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
    check("t1_cnt_clr", dissync_counter, 0);

    // T2: lane0 marker 3 cycles early
    in_issync = 4'b0001; #1;
    check("t2_pop_t0", out_pop, 4'b1110);
    check("t2_valid_t0", out_rxdata_valid, 0);
    tick();
    check("t2_pop_t1", out_pop, 4'b1110);
    check("t2_valid_t1", out_rxdata_valid, 0);
    tick();
    check("t2_pop_t2", out_pop, 4'b1110);
    tick(); in_issync = 4'hF; #1;
    check("t2_pop_t3", out_pop, 4'hF);
    tick(); in_issync = 4'h0; #1;
    check("t2_locked", lanes_locked, 1);
    check("t2_valid", out_rxdata_valid, 1);

    // T3: align timeout with lane2 never reaching its marker
    timeout_limit = 4'd5; in_issync = 4'b1011; #1;
    check("t3_pop_enter", out_pop, 4'b0100);
    tick();
    check("t3_pop_align", out_pop, 4'b0100);
    for (int i = 0; i < 4; i++) tick();
    check("t3_locked_a4", lanes_locked, 1);
    check("t3_flag_a4", timeout_flag, 0);
    tick();
    check("t3_locked_a5", lanes_locked, 0);
    check("t3_flag_a5", timeout_flag, 1);
    clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
    check("t3_flag_clr", timeout_flag, 0);
    check("t3_cnt_clr", dissync_counter, 0);
    in_issync = 4'hF; tick(); in_issync = 4'h0; timeout_limit = '0; #1;
    check("t3_relocked", lanes_locked, 1);
    check("t3_valid", out_rxdata_valid, 1);

    // T4: lane2 masked out, its marker and dissync ignored
    lane_mask = 4'b1011; in_block_lock = 4'b1011; in_canpop = 4'b1011;
    in_issync = 4'b0100; in_dissync = 4'b0100; #1;
    check("t4_pop", out_pop, 4'b1011);
    check("t4_valid", out_rxdata_valid, 1);
    tick(); in_dissync = 4'h0; #1;
    check("t4_locked", lanes_locked, 1);
    check("t4_cnt", dissync_counter, 0);
    tick();
    check("t4_srst", softreset, 0);
    check("t4_bl", out_blocklock, 4'b1011);
    check("t4_pop2", out_pop, 4'b1011);
    lane_mask = 4'hF; in_block_lock = 4'hF; in_canpop = 4'hF; in_issync = 4'h0;
    tick(); tick();
    check("t4_bl_restore", out_blocklock, 4'hF);

    // T5: soft-reset pulse from a lane1 dissync, second pulse does not extend it
    for (int k = 0; k < 20; k++) begin
      in_dissync = (k == 0 || k == 5) ? 4'b0010 : 4'b0000; #1;
      check($sformatf("t5_srst_k%0d", k), softreset, (k >= 2 && k <= 17));
      tick();
    end
    in_dissync = 4'h0;
    check("t5_unlocked", lanes_locked, 0);

    // T6: counter saturation, then enable low freezes everything
    clear_cnt = 1'b1; tick(); clear_cnt = 1'b0;
    check("t6_cnt_zero", dissync_counter, 0);
    in_dissync = 4'b0001;
    for (int i = 0; i < 20; i++) tick();
    check("t6_cnt_sat", dissync_counter, 4'hF);
    in_dissync = 4'h0; in_enable = 1'b0; clear_cnt = 1'b1; in_block_lock = 4'h0; #1;
    check("t6_pop_dis", out_pop, 0);
    check("t6_valid_dis", out_rxdata_valid, 0);
    tick(); tick(); tick();
    check("t6_cnt_frozen", dissync_counter, 4'hF);
    check("t6_bl_frozen", out_blocklock, 4'hF);
    check("t6_locked_frozen", lanes_locked, 0);
    in_enable = 1'b1; tick(); clear_cnt = 1'b0;
    check("t6_cnt_clr", dissync_counter, 0);
    in_block_lock = 4'hF; tick(); tick(); tick();

    // Remote blocklock forwarding
    in_bl_remote = 16'h4321; in_bl_remote_en = 4'b0110; tick();
    check("rem_lane1", out_bl_remote, 4'h2);
    check("rem_en1", out_bl_remote_en, 1);
    in_bl_remote_en = 4'b0000; tick();
    check("rem_default", out_bl_remote, 4'h4);
    check("rem_en0", out_bl_remote_en, 0);
    in_bl_remote_en = 4'b0001; tick();
    check("rem_lane0", out_bl_remote, 4'h1);

    // Asynchronous reset while aligning
    in_issync = 4'b0001; tick(); #2;
    reset_n = 1'b0; #1;
    check("ar_locked", lanes_locked, 0);
    check("ar_flag", timeout_flag, 0);
    check("ar_cnt", dissync_counter, 0);
    check("ar_bl", out_blocklock, 0);
    reset_n = 1'b1; in_issync = 4'h0; timeout_limit = 4'd1;
    tick(); tick(); tick(); tick();
    check("ar_normal_noflag", timeout_flag, 0);
    check("ar_pop", out_pop, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
